mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 23 ++
 rtl/scan_settle_timer.sv | 50 +++++
 rtl/mux_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared types and constants for the 16:1 mux scan sequencer.
//               Holds the scan FSM state type, channel count, select width
//               and settle counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

endpackage : mux_scan_pkg
`default_nettype wire

// File: rtl/scan_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_settle_timer
// Description : Settle-time counter for the mux scan sequencer. Counts up
//               while enabled, returns to zero on clear, and flags expire
//               when the count reaches SETTLE_CYCLES-1.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               clear  - force count to zero (has priority over enable)
//               enable - increment count
//               expire - count == SETTLE_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module scan_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  import mux_scan_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LAST_CNT);

endmodule : scan_settle_timer
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Scan sequencer for a structural 16:1 mux. Steps mux_sel
//               through channels 0..15, waits SETTLE_CYCLES on each, samples
//               mux_out into a 16-bit snapshot and offers the finished
//               snapshot on a valid/ready handshake. Optional continuous
//               re-scan after each accepted snapshot.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start              - request one scan (sampled in IDLE)
//               continuous         - auto re-scan after each handshake
//               mux_sel            - registered select to the mux
//               mux_out            - mux output (combinational of mux_sel)
//               busy               - high in every state except IDLE
//               snap_data          - bit i = mux_out sampled at mux_sel == i
//               snap_valid         - snapshot available
//               snap_ready         - downstream accepts snapshot
//               snap_changed       - (MUX_SCAN_CHANGE_DETECT_EN only)
//                                    snapshot differs from last accepted one
// Options     : MUX_SCAN_CHANGE_DETECT_EN - adds snap_changed output and a
//               register holding the previously accepted snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_CH        = 16,
  parameter int SEL_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_out,
  output logic              busy,
  output logic [NUM_CH-1:0] snap_data,
  output logic              snap_valid,
`ifdef MUX_SCAN_CHANGE_DETECT_EN
  output logic              snap_changed,
`endif
  input  logic              snap_ready
);
  import mux_scan_pkg::*;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  scan_state_t       state_q,      state_d;
  logic [SEL_W-1:0]  mux_sel_q,    mux_sel_d;
  logic              busy_q,       busy_d;
  logic [NUM_CH-1:0] snap_data_q,  snap_data_d;
  logic              snap_valid_q, snap_valid_d;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
  logic [NUM_CH-1:0] prev_q,       prev_d;
  logic              snap_changed_q, snap_changed_d;
`endif

  logic settle_expire;

  // Counter runs only in SETTLE and is held at zero everywhere else, so each
  // entry into SETTLE starts a fresh settle interval.
  scan_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != SETTLE),
    .enable (state_q == SETTLE),
    .expire (settle_expire)
  );

  always_comb begin
    state_d      = state_q;
    mux_sel_d    = mux_sel_q;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    prev_d         = prev_q;
    snap_changed_d = snap_changed_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SETTLE;
          mux_sel_d = '0;
        end
      end

      SETTLE: begin
        if (settle_expire) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        snap_data_d[mux_sel_q] = mux_out;
        if (mux_sel_q == LAST_SEL) begin
          // Select stays at the last channel until the handshake restarts
          // or idles the scan.
          state_d      = DONE;
          snap_valid_d = 1'b1;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
          snap_changed_d = (snap_data_d != prev_q);
`endif
        end else begin
          state_d   = SETTLE;
          mux_sel_d = mux_sel_q + 1'b1;
        end
      end

      DONE: begin
        if (snap_ready) begin
          snap_valid_d = 1'b0;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
          prev_d         = snap_data_q;
          snap_changed_d = 1'b0;
`endif
          if (continuous) begin
            state_d   = SETTLE;
            mux_sel_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mux_sel_q    <= '0;
      busy_q       <= 1'b0;
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
      prev_q         <= '0;
      snap_changed_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mux_sel_q    <= mux_sel_d;
      busy_q       <= busy_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
      prev_q         <= prev_d;
      snap_changed_q <= snap_changed_d;
`endif
    end
  end

  assign mux_sel    = mux_sel_q;
  assign busy       = busy_q;
  assign snap_data  = snap_data_q;
  assign snap_valid = snap_valid_q;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
  assign snap_changed = snap_changed_q;
`endif

endmodule : mux_scan_ctrl
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Self-checking bench for mux_scan_ctrl. Two instances
//               (SETTLE_CYCLES = 1 and 3) each read a modelled 16:1 mux.
//               A scan-position model predicts every output each cycle;
//               directed scenarios add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

  localparam int S0 = 1;
  localparam int S1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [1:0]        start_v;
  logic [1:0]        cont_v;
  logic [1:0]        ready_v;
  logic [1:0][15:0]  in_v;

  logic [3:0]        sel0, sel1;
  logic              busy0, busy1;
  logic [15:0]       data0, data1;
  logic              valid0, valid1;
  logic              chg0, chg1;
  logic              mux_out0, mux_out1;

  // Mux models: output is purely combinational from the select.
  assign mux_out0 = in_v[0][sel0];
  assign mux_out1 = in_v[1][sel1];

  mux_scan_ctrl #(.SETTLE_CYCLES(S0), .NUM_CH(16), .SEL_W(4)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_v[0]),
    .continuous   (cont_v[0]),
    .mux_sel      (sel0),
    .mux_out      (mux_out0),
    .busy         (busy0),
    .snap_data    (data0),
    .snap_valid   (valid0),
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    .snap_changed (chg0),
`endif
    .snap_ready   (ready_v[0])
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(S1), .NUM_CH(16), .SEL_W(4)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_v[1]),
    .continuous   (cont_v[1]),
    .mux_sel      (sel1),
    .mux_out      (mux_out1),
    .busy         (busy1),
    .snap_data    (data1),
    .snap_valid   (valid1),
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    .snap_changed (chg1),
`endif
    .snap_ready   (ready_v[1])
  );

`ifndef MUX_SCAN_CHANGE_DETECT_EN
  assign chg0 = 1'b0;
  assign chg1 = 1'b0;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit cmp_en  = 1'b0;

  // ---------------- behavioural model ----------------
  // m_pos = cycle index within the current scan (-1 when not scanning).
  // Channel = pos/(S+1); the last cycle of each channel slot is the sample.
  int         m_pos  [2];
  bit         m_done [2];
  logic [15:0] m_data[2];
  logic [15:0] m_prev[2];
  logic [3:0] m_sel  [2];
  bit         m_chg  [2];

  initial begin
    int s, per, ch;
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = -1; m_done[k] = 0; m_data[k] = '0; m_prev[k] = '0;
      m_sel[k] = '0; m_chg[k] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          m_pos[k] = -1; m_done[k] = 0; m_data[k] = '0; m_prev[k] = '0;
          m_sel[k] = '0; m_chg[k] = 0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          s   = (k == 0) ? S0 : S1;
          per = s + 1;
          if (m_pos[k] >= 0) begin
            ch = m_pos[k] / per;
            if ((m_pos[k] % per) == s) m_data[k][ch] = in_v[k][ch];
            if (m_pos[k] == 16 * per - 1) begin
              m_pos[k]  = -1;
              m_done[k] = 1;
              m_chg[k]  = (m_data[k] != m_prev[k]);
            end else begin
              m_pos[k] = m_pos[k] + 1;
            end
          end else if (m_done[k]) begin
            if (ready_v[k]) begin
              m_done[k] = 0;
              m_prev[k] = m_data[k];
              m_chg[k]  = 0;
              if (cont_v[k]) m_pos[k] = 0;
            end
          end else if (start_v[k]) begin
            m_pos[k] = 0;
          end
          if (m_pos[k] >= 0) m_sel[k] = 4'(m_pos[k] / per);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [3:0]  a_sel;
    logic        a_busy, a_valid, a_chg, e_busy, e_chg;
    logic [15:0] a_data;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int k = 0; k < 2; k++) begin
          a_sel   = (k == 0) ? sel0   : sel1;
          a_busy  = (k == 0) ? busy0  : busy1;
          a_valid = (k == 0) ? valid0 : valid1;
          a_data  = (k == 0) ? data0  : data1;
          a_chg   = (k == 0) ? chg0   : chg1;
          e_busy  = (m_pos[k] >= 0) || m_done[k];
`ifdef MUX_SCAN_CHANGE_DETECT_EN
          e_chg   = m_chg[k];
`else
          e_chg   = 1'b0;
`endif
          cmp_cnt++;
          if (a_sel !== m_sel[k] || a_busy !== e_busy || a_valid !== m_done[k] ||
              a_data !== m_data[k] || a_chg !== e_chg) begin
            err_cnt++;
            $display("FAIL model_cmp inst%0d t=%0t: got sel=%h busy=%b valid=%b data=%h chg=%b, expected sel=%h busy=%b valid=%b data=%h chg=%b",
                     k, $time, a_sel, a_busy, a_valid, a_data, a_chg,
                     m_sel[k], e_busy, m_done[k], m_data[k], e_chg);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_valid(input int k);
    return (k == 0) ? valid0 : valid1;
  endfunction

  // Pulse start for one edge (edge 0); returns right after that edge's negedge.
  task automatic start_scan(input int k);
    @(negedge clk);
    start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  // Counts rising edges until snap_valid is seen (#1 after each edge).
  task automatic wait_valid(input int k, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      #1;
    end while (!get_valid(k) && cycles < budget);
    if (!get_valid(k)) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int c;
    logic [15:0] held;
    rst_n = 1'b0; start_v = '0; cont_v = '0; ready_v = '0;
    in_v[0] = '0; in_v[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel",   {28'd0, sel0},   32'd0);
    chk("rst_busy",  {31'd0, busy0},  32'd0);
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_data",  {16'd0, data0},  32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Continuous back-to-back: FFFF then 0000, no IDLE in between.
    in_v[0] = 16'hFFFF; cont_v[0] = 1'b1; ready_v[0] = 1'b0;
    start_scan(0);
    wait_valid(0, 100, c);
    chk("cont1_latency", c, 32'd32);
    chk("cont1_data", {16'd0, data0}, 32'h0000FFFF);
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    chk("cont1_changed", {31'd0, chg0}, 32'd1);
`endif
    @(negedge clk);
    in_v[0] = 16'h0000; ready_v[0] = 1'b1;
    @(posedge clk); #1;
    chk("cont_no_idle_busy", {31'd0, busy0}, 32'd1);
    chk("cont_restart_sel",  {28'd0, sel0},  32'd0);
    @(negedge clk);
    ready_v[0] = 1'b0;
    wait_valid(0, 100, c);
    chk("cont2_latency", c, 32'd32);
    chk("cont2_data", {16'd0, data0}, 32'h00000000);
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    chk("cont2_changed", {31'd0, chg0}, 32'd1);
`endif
    @(negedge clk);
    cont_v[0] = 1'b0; ready_v[0] = 1'b1;
    @(posedge clk); #1;
    chk("cont_stop_idle", {31'd0, busy0}, 32'd0);

    // Single scan of A5C3, ready held high.
    in_v[0] = 16'hA5C3;
    start_scan(0);
    wait_valid(0, 100, c);
    chk("a5c3_latency", c, 32'd32);
    chk("a5c3_data", {16'd0, data0}, 32'h0000A5C3);
    chk("a5c3_last_sel", {28'd0, sel0}, 32'd15);
    @(posedge clk); #1;
    chk("a5c3_idle_after_hs", {31'd0, busy0}, 32'd0);

    // Backpressure in DONE, plus a start pulse mid-scan that must be ignored.
    @(negedge clk);
    in_v[0] = 16'h3C3C; ready_v[0] = 1'b0;
    start_scan(0);
    repeat (5) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_valid(0, 100, c);
    held = data0;
    chk("hold_data", {16'd0, held}, 32'h00003C3C);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, valid0}, 32'd1);
      chk("hold_stable", {16'd0, data0}, {16'd0, held});
    end
    @(negedge clk);
    ready_v[0] = 1'b1;
    @(posedge clk); #1;
    chk("hold_idle_busy",  {31'd0, busy0},  32'd0);
    chk("hold_idle_valid", {31'd0, valid0}, 32'd0);

    // Same snapshot twice: changed on first, unchanged on second.
    in_v[0] = 16'h1234;
    for (int r = 0; r < 2; r++) begin
      start_scan(0);
      wait_valid(0, 100, c);
      chk("rep_data", {16'd0, data0}, 32'h00001234);
`ifdef MUX_SCAN_CHANGE_DETECT_EN
      chk("rep_changed", {31'd0, chg0}, (r == 0) ? 32'd1 : 32'd0);
`endif
      @(posedge clk);
    end

    // Asynchronous reset mid-scan while sel == 7 in SETTLE.
    in_v[0] = 16'h5555;
    start_scan(0);
    c = 0;
    while (sel0 != 4'd7 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("rst_mid_reached_sel7", {28'd0, sel0}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_sel",   {28'd0, sel0},   32'd0);
    chk("rst_mid_busy",  {31'd0, busy0},  32'd0);
    chk("rst_mid_valid", {31'd0, valid0}, 32'd0);
    chk("rst_mid_data",  {16'd0, data0},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_v[0] = 16'h00F0;
    start_scan(0);
    wait_valid(0, 100, c);
    chk("post_rst_latency", c, 32'd32);
    chk("post_rst_data", {16'd0, data0}, 32'h000000F0);

    // SETTLE_CYCLES = 3 instance: 4 cycles per channel, 64 to valid.
    @(negedge clk);
    in_v[1] = 16'h0001; ready_v[1] = 1'b1;
    start_scan(1);
    wait_valid(1, 200, c);
    chk("s3_latency", c, 32'd64);
    chk("s3_data", {16'd0, data1}, 32'h00000001);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule : tb_mux_scan_ctrl
`default_nettype wire
